dkjr_sprite_linebuf_ctrl: RTL and testbench

//  Ping-pong sprite line-buffer controller. It drives two 256x4 single-port BRAMs (buffers A and B).
//  - Draw side: the sprite engine writes one scanline into the draw buffer, one pixel per handshake.
//  - Scan side: the video timing reads the other (display) buffer pixel by pixel, then clears each pixel.
//  - Roles swap on every line_start. Sits between the sprite engine and the colour/palette mixer.

---
 rtl/dkjr_video_pkg.sv | 46 ++++
 rtl/dkjr_lb_scan_pipe.sv | 73 +++++++
 rtl/dkjr_sprite_linebuf_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_dkjr_sprite_linebuf_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dkjr_video_pkg.sv
// Shared constants and types for the sprite line-buffer controller.
// A buffer id of 0 selects line buffer A and 1 selects line buffer B.
package dkjr_video_pkg;

  localparam int PIX_W    = 4;
  localparam int X_W      = 8;
  localparam int LB_DEPTH = 2 ** X_W;

  localparam logic [PIX_W-1:0] PIX_TRANSPARENT = 4'd0;
  localparam logic [X_W-1:0]   X_LAST          = 8'd255;

  typedef enum logic [2:0] {
    INIT = 3'd0,
    IDLE = 3'd1,
    RD   = 3'd2,
    CHK  = 3'd3,
    WR   = 3'd4
  } draw_state_e;

  typedef struct packed {
    logic             ce;
    logic             wre;
    logic [X_W-1:0]   ad;
    logic [PIX_W-1:0] din;
  } lb_port_t;

  function automatic lb_port_t port_idle();
    lb_port_t p;
    p.ce  = 1'b0;
    p.wre = 1'b0;
    p.ad  = 8'd0;
    p.din = 4'd0;
    return p;
  endfunction

  function automatic lb_port_t port_access(input logic wre, input logic [X_W-1:0] ad,
                                           input logic [PIX_W-1:0] din);
    lb_port_t p;
    p.ce  = 1'b1;
    p.wre = wre;
    p.ad  = ad;
    p.din = din;
    return p;
  endfunction

endpackage

// File: rtl/dkjr_lb_scan_pipe.sv
// Display-side scan pipeline.
// Reads the display buffer on pixel_ce, registers the pixel, then clears that pixel.
module dkjr_lb_scan_pipe
  import dkjr_video_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable_i,
  input  logic             pixel_ce_i,
  input  logic             buf_sel_i,
  input  logic [X_W-1:0]   hcnt_i,
  input  logic [PIX_W-1:0] a_dout_i,
  input  logic [PIX_W-1:0] b_dout_i,
  output logic             rd_en_o,
  output logic             rd_id_o,
  output logic [X_W-1:0]   rd_ad_o,
  output logic             clr_en_o,
  output logic             clr_id_o,
  output logic [X_W-1:0]   clr_ad_o,
  output logic [PIX_W-1:0] pix_out_o
);

  logic             busy_q, busy_d;
  logic             id_q, id_d;
  logic [X_W-1:0]   ad_q, ad_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             rd_en_s;

  // Read request and next-state; a pixel_ce while the clear is pending is dropped
  always_comb begin
    rd_en_s = enable_i && pixel_ce_i && !busy_q;
    busy_d  = rd_en_s;
    id_d    = id_q;
    ad_d    = ad_q;
    pix_d   = pix_q;
    if (rd_en_s) begin
      id_d = !buf_sel_i;
      ad_d = hcnt_i;
    end else begin
      id_d = id_q;
      ad_d = ad_q;
    end
    if (busy_q) begin
      pix_d = id_q ? b_dout_i : a_dout_i;
    end else begin
      pix_d = pix_q;
    end
  end

  // Pipeline registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      id_q   <= 1'b0;
      ad_q   <= 8'd0;
      pix_q  <= PIX_TRANSPARENT;
    end else begin
      busy_q <= busy_d;
      id_q   <= id_d;
      ad_q   <= ad_d;
      pix_q  <= pix_d;
    end
  end

  assign rd_en_o   = rd_en_s;
  assign rd_id_o   = !buf_sel_i;
  assign rd_ad_o   = hcnt_i;
  assign clr_en_o  = busy_q;
  assign clr_id_o  = id_q;
  assign clr_ad_o  = ad_q;
  assign pix_out_o = pix_q;

endmodule

// File: rtl/dkjr_sprite_linebuf_ctrl.sv
// Ping-pong sprite line-buffer controller: draw FSM, power-up clear, buffer swap and A/B port muxing.
module dkjr_sprite_linebuf_ctrl
  import dkjr_video_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             line_start,
  input  logic             pixel_ce,
  input  logic [X_W-1:0]   hcnt,
  input  logic             px_valid,
  input  logic [X_W-1:0]   px_x,
  input  logic [PIX_W-1:0] px_col,
  output logic             px_ready,
  output logic [PIX_W-1:0] pix_out,
  output logic             buf_sel,
  output logic [X_W-1:0]   a_ad,
  output logic [PIX_W-1:0] a_din,
  output logic             a_wre,
  output logic             a_ce,
  output logic             a_oce,
  input  logic [PIX_W-1:0] a_dout,
  output logic [X_W-1:0]   b_ad,
  output logic [PIX_W-1:0] b_din,
  output logic             b_wre,
  output logic             b_ce,
  output logic             b_oce,
  input  logic [PIX_W-1:0] b_dout
);

  draw_state_e      state_q, state_d;
  logic [X_W-1:0]   cnt_q, cnt_d;
  logic             buf_sel_q, buf_sel_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [PIX_W-1:0] col_q, col_d;

  logic             px_ready_s;
  logic             init_s;
  lb_port_t         init_p_s, draw_p_s, rd_p_s, clr_p_s;
  lb_port_t         a_p_s, b_p_s;
  logic [PIX_W-1:0] draw_dout_s;

  logic             rd_en_s, rd_id_s, clr_en_s, clr_id_s;
  logic [X_W-1:0]   rd_ad_s, clr_ad_s;

  assign init_s      = (state_q == INIT);
  assign draw_dout_s = buf_sel_q ? b_dout : a_dout;

  dkjr_lb_scan_pipe u_scan (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable_i   (!init_s),
    .pixel_ce_i (pixel_ce),
    .buf_sel_i  (buf_sel_q),
    .hcnt_i     (hcnt),
    .a_dout_i   (a_dout),
    .b_dout_i   (b_dout),
    .rd_en_o    (rd_en_s),
    .rd_id_o    (rd_id_s),
    .rd_ad_o    (rd_ad_s),
    .clr_en_o   (clr_en_s),
    .clr_id_o   (clr_id_s),
    .clr_ad_o   (clr_ad_s),
    .pix_out_o  (pix_out)
  );

  // Draw FSM next-state, power-up clear counter and buffer swap
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_sel_d  = buf_sel_q;
    x_d        = x_q;
    col_d      = col_q;
    px_ready_s = 1'b0;
    init_p_s   = port_idle();
    draw_p_s   = port_idle();
    case (state_q)
      INIT: begin
        init_p_s = port_access(1'b1, cnt_q, PIX_TRANSPARENT);
        cnt_d    = cnt_q + 8'd1;
        if (cnt_q == X_LAST) begin
          state_d = IDLE;
        end else begin
          state_d = INIT;
        end
      end
      IDLE: begin
        px_ready_s = !line_start;
        if (px_valid && !line_start) begin
          x_d   = px_x;
          col_d = px_col;
          if (px_col != PIX_TRANSPARENT) begin
            state_d = RD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        draw_p_s = port_access(1'b0, x_q, col_q);
        state_d  = CHK;
      end
      CHK: begin
        // First-drawn pixel wins: only an empty slot is written
        if (draw_dout_s == PIX_TRANSPARENT) begin
          state_d = WR;
        end else begin
          state_d = IDLE;
        end
      end
      WR: begin
        if (!line_start) begin
          draw_p_s = port_access(1'b1, x_q, col_q);
        end else begin
          draw_p_s = port_idle();
        end
        state_d = IDLE;
      end
      default: begin
        state_d = INIT;
        cnt_d   = 8'd0;
      end
    endcase
    if (line_start && !init_s) begin
      buf_sel_d = !buf_sel_q;
      state_d   = IDLE;
    end else begin
      buf_sel_d = buf_sel_q;
    end
  end

  // Draw FSM and swap registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= INIT;
      cnt_q     <= 8'd0;
      buf_sel_q <= 1'b0;
      x_q       <= 8'd0;
      col_q     <= PIX_TRANSPARENT;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      buf_sel_q <= buf_sel_d;
      x_q       <= x_d;
      col_q     <= col_d;
    end
  end

  // Per-buffer port mux: scan clear, scan read, power-up clear, then draw
  always_comb begin
    rd_p_s  = port_access(1'b0, rd_ad_s, PIX_TRANSPARENT);
    clr_p_s = port_access(1'b1, clr_ad_s, PIX_TRANSPARENT);
    a_p_s   = port_idle();
    b_p_s   = port_idle();
    if (!reset_n) begin
      a_p_s = port_idle();
      b_p_s = port_idle();
    end else begin
      if (clr_en_s && !clr_id_s) begin
        a_p_s = clr_p_s;
      end else if (rd_en_s && !rd_id_s) begin
        a_p_s = rd_p_s;
      end else if (init_s) begin
        a_p_s = init_p_s;
      end else if (!buf_sel_q) begin
        a_p_s = draw_p_s;
      end else begin
        a_p_s = port_idle();
      end
      if (clr_en_s && clr_id_s) begin
        b_p_s = clr_p_s;
      end else if (rd_en_s && rd_id_s) begin
        b_p_s = rd_p_s;
      end else if (init_s) begin
        b_p_s = init_p_s;
      end else if (buf_sel_q) begin
        b_p_s = draw_p_s;
      end else begin
        b_p_s = port_idle();
      end
    end
  end

  assign px_ready = px_ready_s;
  assign buf_sel  = buf_sel_q;
  assign a_ad     = a_p_s.ad;
  assign a_din    = a_p_s.din;
  assign a_wre    = a_p_s.wre;
  assign a_ce     = a_p_s.ce;
  assign a_oce    = 1'b1;
  assign b_ad     = b_p_s.ad;
  assign b_din    = b_p_s.din;
  assign b_wre    = b_p_s.wre;
  assign b_ce     = b_p_s.ce;
  assign b_oce    = 1'b1;

endmodule

// File: tb/tb_dkjr_sprite_linebuf_ctrl.sv
// Directed self-checking bench for the sprite line-buffer controller with behavioural BRAMs.
module tb_dkjr_sprite_linebuf_ctrl;

  logic       clk = 1'b0;
  logic       reset_n, line_start, pixel_ce, px_valid;
  logic [7:0] hcnt, px_x;
  logic [3:0] px_col;
  logic       px_ready, buf_sel;
  logic [3:0] pix_out;
  logic [7:0] a_ad, b_ad;
  logic [3:0] a_din, b_din;
  logic       a_wre, a_ce, a_oce, b_wre, b_ce, b_oce;
  logic [3:0] a_dout = 4'd0;
  logic [3:0] b_dout = 4'd0;

  logic [3:0] mem_a [256] = '{default: 4'hA};
  logic [3:0] mem_b [256] = '{default: 4'h6};
  int         b_wr20 = 0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dkjr_sprite_linebuf_ctrl dut (
    .clk(clk), .reset_n(reset_n), .line_start(line_start), .pixel_ce(pixel_ce),
    .hcnt(hcnt), .px_valid(px_valid), .px_x(px_x), .px_col(px_col),
    .px_ready(px_ready), .pix_out(pix_out), .buf_sel(buf_sel),
    .a_ad(a_ad), .a_din(a_din), .a_wre(a_wre), .a_ce(a_ce), .a_oce(a_oce), .a_dout(a_dout),
    .b_ad(b_ad), .b_din(b_din), .b_wre(b_wre), .b_ce(b_ce), .b_oce(b_oce), .b_dout(b_dout)
  );

  // Single-port BRAMs in bypass read mode
  always @(posedge clk) begin
    if (a_ce) begin
      if (a_wre) begin
        mem_a[a_ad] <= a_din;
        a_dout      <= a_din;
      end else begin
        a_dout <= mem_a[a_ad];
      end
    end
    if (b_ce) begin
      if (b_wre) begin
        mem_b[b_ad] <= b_din;
        b_dout      <= b_din;
      end else begin
        b_dout <= mem_b[b_ad];
      end
    end
    if (b_ce && b_wre && b_ad == 8'd20 && b_din != 4'd0) b_wr20 <= b_wr20 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic draw(input logic [7:0] x, input logic [3:0] col);
    px_valid = 1'b1;
    px_x     = x;
    px_col   = col;
    chk("draw_ready", {31'd0, px_ready}, 32'd1);
    tick();
    px_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic swap();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic scan(input logic [7:0] h);
    pixel_ce = 1'b1;
    hcnt     = h;
    tick();
    pixel_ce = 1'b0;
    tick();
  endtask

  initial begin
    int   ready_low;
    int   ready_err;
    int   ce_err;
    int   wr_before;
    reset_n = 1'b0; line_start = 1'b0; pixel_ce = 1'b0; px_valid = 1'b0;
    hcnt = 8'd0; px_x = 8'd0; px_col = 4'd0;

    // Test 1: reset state, power-up clear, ignored controls during clear
    repeat (3) tick();
    chk("rst_px_ready", {31'd0, px_ready}, 32'd0);
    chk("rst_pix_out", {28'd0, pix_out}, 32'd0);
    chk("rst_buf_sel", {31'd0, buf_sel}, 32'd0);
    chk("rst_ports", {28'd0, a_ce, a_wre, b_ce, b_wre}, 32'd0);
    chk("rst_addr", {16'd0, a_ad, b_ad}, 32'd0);
    reset_n   = 1'b1;
    ready_low = 0;
    for (int i = 0; i < 256; i++) begin
      pixel_ce   = (i % 3 == 0);
      hcnt       = 8'(i);
      line_start = (i == 100);
      if (px_ready === 1'b0) ready_low++;
      tick();
    end
    pixel_ce = 1'b0; line_start = 1'b0;
    chk("init_ready_low_cycles", ready_low, 32'd256);
    chk("init_done_ready", {31'd0, px_ready}, 32'd1);
    chk("init_buf_sel", {31'd0, buf_sel}, 32'd0);
    chk("init_pix_out", {28'd0, pix_out}, 32'd0);
    chk("init_clear_a", {20'd0, mem_a[0], mem_a[128], mem_a[255]}, 32'd0);
    chk("init_clear_b", {20'd0, mem_b[0], mem_b[128], mem_b[255]}, 32'd0);

    // Test 2: draw, swap, scan, clear-after-read
    draw(8'd10, 4'd5);
    chk("t2_mem_a10", {28'd0, mem_a[10]}, 32'd5);
    swap();
    chk("t2_buf_sel", {31'd0, buf_sel}, 32'd1);
    scan(8'd10);
    chk("t2_pix_out", {28'd0, pix_out}, 32'd5);
    chk("t2_cleared", {28'd0, mem_a[10]}, 32'd0);
    swap();
    swap();
    scan(8'd10);
    chk("t2_rescan_zero", {28'd0, pix_out}, 32'd0);

    // Test 3: first-drawn pixel wins (draw buffer is B)
    wr_before = b_wr20;
    draw(8'd20, 4'd3);
    draw(8'd20, 4'd7);
    chk("t3_one_write", b_wr20 - wr_before, 32'd1);
    swap();
    scan(8'd20);
    chk("t3_pix_out", {28'd0, pix_out}, 32'd3);

    // Test 4: transparent pixels never touch the draw buffer (A)
    ready_err = 0; ce_err = 0;
    px_valid = 1'b1; px_x = 8'd30; px_col = 4'd0;
    for (int i = 0; i < 4; i++) begin
      if (px_ready !== 1'b1) ready_err++;
      if (a_ce !== 1'b0) ce_err++;
      tick();
    end
    px_valid = 1'b0;
    if (a_ce !== 1'b0) ce_err++;
    chk("t4_ready_every_clk", ready_err, 32'd0);
    chk("t4_no_draw_ce", ce_err, 32'd0);
    chk("t4_mem_a30", {28'd0, mem_a[30]}, 32'd0);

    // Test 5: line_start while the FSM is in CHK drops the pixel
    px_valid = 1'b1; px_x = 8'd40; px_col = 4'd9;
    tick();
    px_valid = 1'b0;
    tick();
    line_start = 1'b1;
    #1;
    chk("t5_ready_at_T", {31'd0, px_ready}, 32'd0);
    tick();
    line_start = 1'b0;
    #1;
    chk("t5_ready_at_T1", {31'd0, px_ready}, 32'd1);
    chk("t5_buf_sel", {31'd0, buf_sel}, 32'd1);
    repeat (3) tick();
    chk("t5_no_write", {24'd0, mem_a[40], mem_b[40]}, 32'd0);
    scan(8'd40);
    chk("t5_pix_out", {28'd0, pix_out}, 32'd0);

    // Test 6: address wrap boundaries and ignored back-to-back pixel_ce (draw buffer B)
    draw(8'd255, 4'd2);
    draw(8'd0, 4'd4);
    swap();
    pixel_ce = 1'b1; hcnt = 8'd255;
    tick();
    hcnt = 8'd0;
    tick();
    pixel_ce = 1'b0;
    chk("t6_pix_255", {28'd0, pix_out}, 32'd2);
    tick();
    chk("t6_ignored_ce", {28'd0, pix_out}, 32'd2);
    chk("t6_mem_b0_kept", {28'd0, mem_b[0]}, 32'd4);
    scan(8'd0);
    chk("t6_pix_0", {28'd0, pix_out}, 32'd4);
    chk("t6_cleared", {24'd0, mem_b[255], mem_b[0]}, 32'd0);

    // Mid-operation reset restarts the power-up clear
    swap();
    chk("rst2_pre_buf_sel", {31'd0, buf_sel}, 32'd1);
    reset_n = 1'b0;
    tick();
    chk("rst2_buf_sel", {31'd0, buf_sel}, 32'd0);
    chk("rst2_pix_out", {28'd0, pix_out}, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("rst2_init_write", {29'd0, a_ce, a_wre, px_ready}, 32'd6);
    repeat (2) tick();
    chk("rst2_ready", {31'd0, px_ready}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
